// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC definitions: opcode constants and the divider state encoding.
// Used by the control unit, the ALU and div_seq_32 so they agree on encodings.
package mini_src_pkg;

  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  function automatic logic is_div(input logic [4:0] opcode);
    return opcode == OP_DIV;
  endfunction

endpackage

// File: rtl/div_step_32.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep or restore the partial remainder.
module div_step_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {rem, dividend_bit};
    trial    = shifted - {1'b0, divisor};
    // Borrow out of the extra top bit means the trial went negative.
    quo_bit  = ~trial[WIDTH];
    rem_next = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq_32.sv
// Iterative 32-bit signed restoring divider: quotient to LO, remainder to HI.
// Optional macro DIV_ZERO_TRAP_EN: early exit and dz flag on a zero divisor.
//
// state | meaning
// IDLE  | waiting for start; operands and signs latched on start
// RUN   | one restoring step per cycle, 32 steps
// FIX   | sign correction, results registered, done pulsed
module div_seq_32
  import mini_src_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] R,
  output logic             dz
);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] m_mag;
  logic             q_bit;
  logic             sign_a;
  logic             sign_m;
  logic             last_step;
  logic             trap;

  assign a_mag     = A[WIDTH-1] ? -A : A;
  assign m_mag     = M[WIDTH-1] ? -M : M;
  assign busy      = (state != IDLE);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_TRAP_EN
  logic zero_pend;
  assign trap = zero_pend;
`else
  assign trap = 1'b0;
  assign dz   = 1'b0;
`endif

  div_step_32 #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_bit (dvd[WIDTH-1]),
    .divisor      (dvs),
    .rem_next     (rem_nxt),
    .quo_bit      (q_bit)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      // A trapped zero divisor spends a single non-stepping RUN cycle.
      RUN:  if (last_step || trap) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      sign_a <= 1'b0;
      sign_m <= 1'b0;
      done   <= 1'b0;
      Quo    <= '0;
      R      <= '0;
`ifdef DIV_ZERO_TRAP_EN
      zero_pend <= 1'b0;
      dz        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd    <= a_mag;
            dvs    <= m_mag;
            rem    <= '0;
            cnt    <= '0;
            sign_a <= A[WIDTH-1];
            sign_m <= M[WIDTH-1];
`ifdef DIV_ZERO_TRAP_EN
            zero_pend <= (M == '0);
`endif
          end
        end
        RUN: begin
          // dvd doubles as the quotient: dividend bits leave at the top
          // while quotient bits enter at the bottom.
          if (!trap) begin
            dvd <= {dvd[WIDTH-2:0], q_bit};
            rem <= rem_nxt;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          done <= 1'b1;
          if (trap) begin
            Quo <= '0;
            R   <= sign_a ? -dvd : dvd;
          end else begin
            Quo <= (sign_a ^ sign_m) ? -dvd : dvd;
            R   <= sign_a ? -rem : rem;
          end
`ifdef DIV_ZERO_TRAP_EN
          dz <= trap;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: arithmetic reference model plus
// directed vectors with literal expectations.
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] M = '0;
  logic        busy;
  logic        done;
  logic [31:0] Quo;
  logic [31:0] R;
  logic        dz;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int ZLAT = TRAP ? 2 : 33;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq_32 dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .A     (A),
    .M     (M),
    .busy  (busy),
    .done  (done),
    .Quo   (Quo),
    .R     (R),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic, truncated to 32 bits.
  task automatic expect_div(input logic [31:0] a, input logic [31:0] m,
                            output logic [31:0] q, output logic [31:0] r,
                            output logic z, output int lat);
    longint sa, sm, lq, lr;
    sa = longint'($signed(a));
    sm = longint'($signed(m));
    z = 1'b0;
    lat = 33;
    if (sm == 0) begin
      r = a;
      if (TRAP) begin
        q = 32'h0;
        z = 1'b1;
        lat = 2;
      end else begin
        q = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
      end
    end else begin
      lq = sa / sm;
      lr = sa % sm;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_quo = '0, m_r = '0;
  logic [31:0] p_quo, p_r;
  logic        p_dz;
  int          left = 0;
  int          p_lat;

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_quo = '0; m_r = '0; left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        left--;
        if (left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_quo = p_quo; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        expect_div(A, M, p_quo, p_r, p_dz, p_lat);
        left = p_lat;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (clear) begin
      check("model busy", busy, m_busy);
      check("model done", done, m_done);
      check("model quo", Quo, m_quo);
      check("model rem", R, m_r);
      check("model dz", dz, m_dz);
    end
  end

  task automatic pulse(input logic [31:0] a, input logic [31:0] m);
    A = a; M = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; M = $urandom;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] m,
                         input logic [31:0] q_exp, input logic [31:0] r_exp,
                         input logic dz_exp, input int lat_exp);
    int c;
    pulse(a, m);
    wait_done(c);
    check({tag, " latency"}, c, lat_exp);
    check({tag, " quo"}, Quo, q_exp);
    check({tag, " rem"}, R, r_exp);
    check({tag, " dz"}, dz, dz_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, seen;
    logic [31:0] ra, rm, eq, er;
    logic ez;
    int el;

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quo", Quo, 0);
    check("reset rem", R, 0);
    check("reset dz", dz, 0);
    @(posedge clk); #1;
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("-100/7", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run_div("100/-7", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
    run_div("5/0", 32'd5, 32'd0, TRAP ? 32'h0 : 32'hFFFF_FFFF, 32'd5, TRAP, ZLAT);
    run_div("-5/0", -32'sd5, 32'd0, TRAP ? 32'h0 : 32'h0000_0001, 32'hFFFF_FFFB, TRAP, ZLAT);
    run_div("7/min", 32'd7, 32'h8000_0000, 32'h0, 32'd7, 1'b0, 33);

    // Second start while busy must be dropped.
    pulse(32'd1000, 32'd10);
    repeat (9) begin @(posedge clk); #1; end
    pulse(32'd7, 32'd2);
    wait_done(c);
    check("ignore latency", 10 + c, 33);
    check("ignore quo", Quo, 32'd100);
    check("ignore rem", R, 32'd0);

    // Start held in the done cycle is accepted.
    pulse(32'd50, 32'd6);
    wait_done(c);
    check("b2b first latency", c, 33);
    check("b2b first quo", Quo, 32'd8);
    check("b2b first rem", R, 32'd2);
    A = 32'd9; M = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b accepted busy", busy, 1);
    wait_done(c);
    check("b2b second latency", c + 1, 34);
    check("b2b second quo", Quo, 32'd2);
    check("b2b second rem", R, 32'd1);

    // Asynchronous abort mid-divide.
    pulse(32'd100, 32'd7);
    repeat (14) begin @(posedge clk); #1; end
    #2;
    clear = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quo", Quo, 0);
    check("abort rem", R, 0);
    check("abort dz", dz, 0);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    run_div("after abort", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

    // Model-checked vectors with assorted magnitudes.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rm = $urandom >> $urandom_range(0, 28);
      if (i == 3) rm = -rm;
      expect_div(ra, rm, eq, er, ez, el);
      pulse(ra, rm);
      wait_done(c);
      check("rand latency", c, el);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
